// File: rtl/insn_prefetch_queue_if.sv
// Instruction-memory request/return bus between the prefetch queue and imem.
// Latency: none; this bundle only carries signals.
// Backpressure: imem_req/imem_addr stay stable until imem_ack.
interface insn_prefetch_queue_if #(
    parameter int ADDR_W = 16
) ();
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [15:0]       imem_data;

    // Prefetch queue side: issues requests and takes returned words.
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_data
    );

    // Memory side: accepts requests and returns words.
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_data
    );
endinterface

// File: rtl/insn_prefetch_queue.sv
// Fetch front end: one imem request in flight, DEPTH-entry word/PC FIFO, ir0/pc0 to decode.
// Latency: a word acked at edge E is in the FIFO after E and on ir0 after E+1; no bypass.
// Backpressure: stall holds ir0/pc0; new requests stop once FIFO entries plus in-flight reach DEPTH.
module insn_prefetch_queue #(
    parameter int                DEPTH    = 4,
    parameter int                ADDR_W   = 16,
    parameter logic [15:0]       NOP_WORD = 16'h0201,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   fetch_en,
    insn_prefetch_queue_if.master  imem,
    input  logic                   redirect,
    input  logic [ADDR_W-1:0]      redirect_pc,
    input  logic                   stall,
    output logic [15:0]            ir0,
    output logic [ADDR_W-1:0]      pc0,
    output logic                   ir0_valid,
    output logic [$clog2(DEPTH):0] q_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  ONE_C   = CNT_W'(1);
    localparam logic [ADDR_W-1:0] PC_INC  = ADDR_W'(1);

    // IDLE: no request. BUSY: request whose word will be kept. DRAIN: request whose word is discarded.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              imem_req_q, imem_req_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;

    logic [15:0]       word_q [DEPTH];
    logic [15:0]       word_d [DEPTH];
    logic [ADDR_W-1:0] pcs_q  [DEPTH];
    logic [ADDR_W-1:0] pcs_d  [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [15:0]       ir0_q, ir0_d;
    logic [ADDR_W-1:0] pc0_q, pc0_d;
    logic              ir0_valid_q, ir0_valid_d;

    logic              ack;
    logic              push;
    logic              pop;
    logic [CNT_W-1:0]  count_after_push;

    // imem_ack only means something while a request is up.
    assign ack = imem_req_q & imem.imem_ack;

    // Output stage: redirect blanks ir0, stall holds it, otherwise pop the FIFO head or show a NOP.
    always_comb begin
        ir0_d       = ir0_q;
        pc0_d       = pc0_q;
        ir0_valid_d = ir0_valid_q;
        pop         = 1'b0;
        if (redirect) begin
            ir0_d       = NOP_WORD;
            ir0_valid_d = 1'b0;
        end else if (stall) begin
            ir0_d       = ir0_q;
        end else if (count_q != '0) begin
            pop         = 1'b1;
            ir0_d       = word_q[rd_ptr_q];
            pc0_d       = pcs_q[rd_ptr_q];
            ir0_valid_d = 1'b1;
        end else begin
            ir0_d       = NOP_WORD;
            ir0_valid_d = 1'b0;
        end
    end

    // Fetch FSM: issue when a FIFO slot is free, chain requests on ack, squash the in-flight word on redirect.
    always_comb begin
        state_d          = state_q;
        imem_req_d       = imem_req_q;
        imem_addr_d      = imem_addr_q;
        fetch_pc_d       = fetch_pc_q;
        push             = 1'b0;
        // Occupancy after this edge's push; the pop matters because it frees a slot at the same edge.
        count_after_push = pop ? count_q : (count_q + ONE_C);
        case (state_q)
            IDLE: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                end else if (fetch_en && (count_q < DEPTH_C)) begin
                    state_d     = BUSY;
                    imem_req_d  = 1'b1;
                    imem_addr_d = fetch_pc_q;
                end
            end
            BUSY: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                    if (ack) begin
                        // Word returns this edge and is simply not pushed.
                        state_d    = IDLE;
                        imem_req_d = 1'b0;
                    end else begin
                        state_d    = DRAIN;
                    end
                end else if (ack) begin
                    push       = 1'b1;
                    fetch_pc_d = imem_addr_q + PC_INC;
                    if (fetch_en && (count_after_push < DEPTH_C)) begin
                        imem_addr_d = imem_addr_q + PC_INC;
                    end else begin
                        state_d    = IDLE;
                        imem_req_d = 1'b0;
                    end
                end
            end
            DRAIN: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                end
                if (ack) begin
                    state_d    = IDLE;
                    imem_req_d = 1'b0;
                end
            end
            default: begin
                state_d    = IDLE;
                imem_req_d = 1'b0;
            end
        endcase
    end

    // FIFO bookkeeping: redirect empties it; push and pop together leave the count unchanged.
    always_comb begin
        word_d   = word_q;
        pcs_d    = pcs_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (redirect) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                word_d[wr_ptr_q] = imem.imem_data;
                pcs_d[wr_ptr_q]  = imem_addr_q;
                wr_ptr_d         = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + ONE_C;
                2'b01:   count_d = count_q - ONE_C;
                default: count_d = count_q;
            endcase
        end
    end

    // All state and outputs are registered; reset abandons any outstanding request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            imem_req_q  <= 1'b0;
            imem_addr_q <= RESET_PC;
            fetch_pc_q  <= RESET_PC;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ir0_q       <= NOP_WORD;
            pc0_q       <= '0;
            ir0_valid_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                word_q[i] <= '0;
                pcs_q[i]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            imem_req_q  <= imem_req_d;
            imem_addr_q <= imem_addr_d;
            fetch_pc_q  <= fetch_pc_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ir0_q       <= ir0_d;
            pc0_q       <= pc0_d;
            ir0_valid_q <= ir0_valid_d;
            for (int i = 0; i < DEPTH; i++) begin
                word_q[i] <= word_d[i];
                pcs_q[i]  <= pcs_d[i];
            end
        end
    end

    assign imem.imem_req  = imem_req_q;
    assign imem.imem_addr = imem_addr_q;
    assign ir0            = ir0_q;
    assign pc0            = pc0_q;
    assign ir0_valid      = ir0_valid_q;
    assign q_count        = count_q;
endmodule
